countdown_timer_bcd: RTL and testbench
======================================

// Module: countdown_timer_bcd
// PURPOSE
//  Two-digit BCD countdown timer paced by the 2 Hz square wave from frequency_divider_2Hz.
//  Sits directly downstream of the divider and upstream of the 7-segment display driver.
//  Samples the slow clock as data in the clk_i domain; no logic is clocked by it.
//  Provides load/start/pause control, a one-cycle done pulse and a steady alarm level.
// PARAMETERS
//  TICKS_PER_STEP  2   slow_clk_i rising edges per count step (2 -> 1 s per step at 2 Hz)
//  PRESC_W         4   prescaler width; must satisfy 2**PRESC_W >= TICKS_PER_STEP
// PORTS
//  clk_i       in   1  system clock (100 MHz board clock)
//  rst_i       in   1  asynchronous, active-low reset
//  slow_clk_i  in   1  2 Hz square wave from frequency_divider_2Hz, asynchronous to clk_i
//  load_i      in   1  load request, sampled every clk_i cycle
//  load_val_i  in   8  BCD start value {tens[7:4], ones[3:0]}
//  start_i     in   1  start/resume request
//  pause_i     in   1  pause request
//  cnt_bcd_o   out  8  current BCD count {tens, ones}
//  state_o     out  2  FSM state (encoding below)
//  done_o      out  1  one clk_i-cycle pulse when the count reaches 00
//  alarm_o     out  1  high while the FSM is in DONE
// BEHAVIOUR
//  Reset (rst_i=0, async):
//   - cnt_bcd_o=8'h00, state_o=IDLE, done_o=0, alarm_o=0.
//   - Sync flops=0, prescaler=0.
//   - Takes effect immediately, including mid-count.
//  Tick generation:
//   - slow_clk_i passes through a 2-FF synchroniser and a rising-edge detector.
//   - This produces tick, exactly one clk_i cycle wide.
//   - tick asserts on the 3rd clk_i rising edge after the slow_clk_i rising edge.
//  Prescaler:
//   - Counts ticks only in RUN; frozen in PAUSE; cleared on load or start-from-IDLE.
//   - step = tick && prescaler==TICKS_PER_STEP-1; the prescaler wraps to 0 on step.
//  Load:
//   - Each nibble >9 is saturated to 9 before storing (8'hA5 -> 8'h95).
//  FSM states: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
//  Priority when requests coincide in one cycle: load_i > start_i > pause_i > step.
//   - load_i, any state: cnt<=sat(load_val_i); ->IDLE; alarm_o<=0.
//   - IDLE: start_i with cnt!=00 -> RUN, prescaler<=0. start_i with cnt==00 is ignored.
//   - RUN: pause_i -> PAUSE; the same-cycle step is dropped (count does not change).
//   - RUN, step: BCD decrement.
//       ones!=0 -> ones-1.
//       ones==0 -> ones<=9, tens-1.
//   - RUN, step with cnt==8'h01: cnt<=00, ->DONE, done_o=1 for that one cycle.
//   - PAUSE: start_i -> RUN with the prescaler value kept. pause_i is ignored.
//   - DONE: alarm_o=1, cnt holds 00. start_i and pause_i are ignored; only load_i leaves DONE.
//  Output timing and value rules:
//   - All outputs are registered and change only on clk_i rising edges.
//   - The count never wraps below 00 and never holds a non-BCD value.
// STRUCTURE
//  - Shared package countdown_pkg: state encoding localparams; BCD_MAX_NIBBLE=4'd9.
//  - Sub-module slow_tick_sync (clk_i, rst_i, async_i, tick_o): 2-FF sync plus rising-edge detect.
//    Reused by other slow-clock consumers.
//  - Top level: prescaler, FSM and BCD decrement logic (~200 lines).
// TESTING
//  Bench setup: drives slow_clk_i directly (period 40 clk_i cycles), TICKS_PER_STEP=2.
//  1 Reset: hold rst_i=0 mid-RUN at cnt=8'h37 -> same cycle: cnt_bcd_o=00, state_o=0, done_o=0, alarm_o=0.
//  2 Load 8'h12, start -> 2 slow edges per step.
//    Sequence 12,11,10,09,...,01,00; state_o=3, done_o high exactly 1 cycle, alarm_o stays 1.
//  3 Borrow/saturate:
//    - Load 8'h20 and run 1 step -> 8'h19.
//    - Load 8'hAF -> cnt_bcd_o=8'h99.
//  4 Pause/resume: RUN at 8'h05 with prescaler=1.
//    - pause_i, then 5 slow edges -> still 05.
//    - start_i, then 1 edge -> 04 (prescaler value retained).
//  5 Coincidence:
//    - pause_i in the same cycle as step -> cnt unchanged, state PAUSE.
//    - load_i=8'h30 with start_i -> IDLE, cnt=30.
//  6 Edge cases:
//    - start_i in IDLE with cnt=00 -> remains IDLE.
//    - start_i in DONE -> remains DONE.
//    - Tick appears 3 clk_i cycles after a slow_clk_i rising edge.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and BCD helpers for the countdown timer.
// Used by the timer top level and its tests.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX_NIBBLE = 4'd9;

    function automatic logic [3:0] nib_sat(input logic [3:0] n);
        return (n > BCD_MAX_NIBBLE) ? BCD_MAX_NIBBLE : n;
    endfunction

    function automatic logic [7:0] bcd_sat(input logic [7:0] v);
        return {nib_sat(v[7:4]), nib_sat(v[3:0])};
    endfunction

    // Floors at 00 so the count can never wrap.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00)
            r = 8'h00;
        else if (v[3:0] != 4'd0)
            r = {v[7:4], v[3:0] - 4'd1};
        else
            r = {v[7:4] - 4'd1, BCD_MAX_NIBBLE};
        return r;
    endfunction

endpackage

// File: rtl/slow_tick_sync.sv
// Two-flop synchroniser plus registered rising-edge detect.
// tick_o is one clk_i cycle wide, 3 edges after async_i rises.
module slow_tick_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic tick_o
);

    logic [2:0] sync_q;
    logic       tick_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= 3'b000;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
            tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/countdown_timer_bcd.sv
// Two-digit BCD countdown timer stepped by a synchronised slow clock.
// Load/start/pause control, done pulse and alarm level.
module countdown_timer_bcd
    import countdown_pkg::*;
#(
    parameter int TICKS_PER_STEP = 2,
    parameter int PRESC_W        = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       slow_clk_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       start_i,
    input  logic       pause_i,
    output logic [7:0] cnt_bcd_o,
    output logic [1:0] state_o,
    output logic       done_o,
    output logic       alarm_o
);

    localparam logic [PRESC_W-1:0] PRESC_LAST =
        PRESC_W'(TICKS_PER_STEP - 1);

    logic               tick;
    logic               step;
    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               done_q, done_d;
    logic               alarm_q, alarm_d;

    slow_tick_sync u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (slow_clk_i),
        .tick_o  (tick)
    );

    assign step = tick && (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (load_i) begin
            cnt_d   = bcd_sat(load_val_i);
            state_d = ST_IDLE;
            presc_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i && cnt_q != 8'h00) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    // Pause wins over a coincident step; prescaler freezes too.
                    if (pause_i) begin
                        state_d = ST_PAUSE;
                    end else if (step) begin
                        presc_d = '0;
                        if (cnt_q == 8'h01) begin
                            cnt_d   = 8'h00;
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = bcd_dec(cnt_q);
                        end
                    end else if (tick) begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (start_i)
                        state_d = ST_RUN;
                end
                ST_DONE: begin
                    cnt_d = 8'h00;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        alarm_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'h00;
            presc_q <= '0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            alarm_q <= alarm_d;
        end
    end

    assign cnt_bcd_o = cnt_q;
    assign state_o   = state_q;
    assign done_o    = done_q;
    assign alarm_o   = alarm_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd.
// Slow clock driven by hand with a 40-cycle period.
module tb_countdown_timer_bcd;

    logic       clk;
    logic       rst_n;
    logic       slow;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [7:0] cnt;
    logic [1:0] state;
    logic       done;
    logic       alarm;

    int checks   = 0;
    int failures = 0;

    countdown_timer_bcd #(.TICKS_PER_STEP(2), .PRESC_W(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .slow_clk_i (slow),
        .load_i     (load),
        .load_val_i (load_val),
        .start_i    (start),
        .pause_i    (pause),
        .cnt_bcd_o  (cnt),
        .state_o    (state),
        .done_o     (done),
        .alarm_o    (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slow_pulse();
        slow = 1'b1;
        cyc(20);
        slow = 1'b0;
        cyc(20);
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        int val;
        rst_n    = 1'b0;
        slow     = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        start    = 1'b0;
        pause    = 1'b0;
        cyc(3);
        chk("rst_cnt", cnt, 8'h00);
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_done_alarm", {6'd0, done, alarm}, 8'd0);
        rst_n = 1'b1;
        cyc(2);

        do_start();
        chk("start_at_00_idle", {6'd0, state}, 8'd0);

        do_load(8'h12);
        chk("load_12", cnt, 8'h12);
        do_start();
        chk("run_state", {6'd0, state}, 8'd1);
        slow_pulse();
        chk("one_edge_no_step", cnt, 8'h12);
        slow = 1'b1;
        cyc(3);
        chk("tick_edge3_no_change", cnt, 8'h12);
        cyc(1);
        chk("tick_edge4_step", cnt, 8'h11);
        cyc(16);
        slow = 1'b0;
        cyc(20);

        val = 11;
        while (val > 1) begin
            slow_pulse();
            slow_pulse();
            val--;
            chk("seq", cnt, to_bcd(val));
        end

        slow_pulse();
        slow = 1'b1;
        cyc(4);
        chk("final_cnt", cnt, 8'h00);
        chk("final_state", {6'd0, state}, 8'd3);
        chk("done_pulse", {7'd0, done}, 8'd1);
        chk("alarm_set", {7'd0, alarm}, 8'd1);
        cyc(1);
        chk("done_one_cycle", {7'd0, done}, 8'd0);
        chk("alarm_stays", {7'd0, alarm}, 8'd1);
        cyc(15);
        slow = 1'b0;
        cyc(20);
        slow_pulse();
        slow_pulse();
        chk("done_hold_cnt", cnt, 8'h00);

        do_start();
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk("start_in_done", {6'd0, state}, 8'd3);
        chk("alarm_in_done", {7'd0, alarm}, 8'd1);

        do_load(8'h20);
        chk("load_clears_alarm", {7'd0, alarm}, 8'd0);
        do_start();
        slow_pulse();
        slow_pulse();
        chk("borrow_20_19", cnt, 8'h19);
        do_load(8'hAF);
        chk("sat_AF", cnt, 8'h99);
        do_load(8'hA5);
        chk("sat_A5", cnt, 8'h95);

        do_load(8'h06);
        do_start();
        slow_pulse();
        slow_pulse();
        chk("pre_pause", cnt, 8'h05);
        slow_pulse();
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk("pause_state", {6'd0, state}, 8'd2);
        for (int i = 0; i < 5; i++) slow_pulse();
        chk("pause_hold", cnt, 8'h05);
        do_start();
        chk("resume_state", {6'd0, state}, 8'd1);
        slow_pulse();
        chk("resume_keeps_presc", cnt, 8'h04);

        slow_pulse();
        slow = 1'b1;
        cyc(3);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk("pause_step_cnt", cnt, 8'h04);
        chk("pause_step_state", {6'd0, state}, 8'd2);
        cyc(16);
        slow = 1'b0;
        cyc(20);

        load     = 1'b1;
        load_val = 8'h30;
        start    = 1'b1;
        cyc(1);
        load  = 1'b0;
        start = 1'b0;
        chk("load_start_state", {6'd0, state}, 8'd0);
        chk("load_start_cnt", cnt, 8'h30);

        do_load(8'h37);
        do_start();
        slow_pulse();
        chk("pre_reset_cnt", cnt, 8'h37);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", cnt, 8'h00);
        chk("async_rst_state", {6'd0, state}, 8'd0);
        chk("async_rst_flags", {6'd0, done, alarm}, 8'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_state", {6'd0, state}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
